// File: rtl/pre_rr_sched_pkg.sv
// Shared types and helpers for the prefetch round-robin read scheduler.
// Holds the FSM state encoding and channel-slice arithmetic used by the top.
package pre_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2
    } sched_state_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

    // LSB position of channel ch inside a flattened N*W data bus.
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pre_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// found is low when disabled or when no request bit is set.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [IDW-1:0] grant,
    output logic           found
);

    logic           hi_any;
    logic           lo_any;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = IDW'(i);
                if (i >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        found = en & lo_any;
        grant = '0;
        if (en) begin
            grant = hi_any ? hi_idx : lo_idx;
        end
    end

endmodule

// File: rtl/pre_rr_sched.sv
// N-channel round-robin read scheduler: grants one prefetched FIFO port at a time
// for a bounded burst and forwards popped words through one registered output stage.
module pre_rr_sched
    import pre_rr_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2,
    parameter int BW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_en,
    input  logic [BW-1:0]  cfg_burst,
    input  logic [N-1:0]   ch_mask,
    input  logic [N-1:0]   ch_vld,
    input  logic [N*W-1:0] ch_data,
    output logic [N-1:0]   ch_rd_en,
    output logic           m_vld,
    output logic [W-1:0]   m_data,
    output logic [IDW-1:0] m_id,
    input  logic           m_rdy,
    output logic           busy
);

    // Handshake: a word moves downstream on any cycle where m_vld & m_rdy; m_data/m_id
    // stay stable while m_vld & ~m_rdy, and a channel pop refills the slot the same cycle
    // it is freed, so accept-plus-pop sustains one word per clock.

    sched_state_e   state;
    sched_state_e   state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] grant_inc;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic           pick_en;
    logic [BW-1:0]  beat_cnt;
    logic [BW-1:0]  burst_lim;
    logic [N-1:0]   req;
    logic           slot_free;
    logic           pop;
    logic           g_vld;
    logic           g_mask;
    logic [W-1:0]   g_data;
    logic           limit_hit;
    logic           burst_done;

    assign req       = ch_vld & ~ch_mask;
    assign slot_free = ~m_vld | m_rdy;
    assign g_vld     = ch_vld[grant];
    assign g_mask    = ch_mask[grant];
    assign pick_en   = (state == ST_ARB) & cfg_en;
    assign grant_inc = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IDW'(i)) begin
                g_data = ch_data[ch_lsb(i, W) +: W];
            end
        end
    end

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .en    (pick_en),
        .grant (pick_idx),
        .found (pick_found)
    );

    assign pop = (state == ST_BURST) & g_vld & slot_free & ~g_mask;

    // A zero limit means the burst only ends on dry, mask or disable.
    assign limit_hit  = pop & (burst_lim != '0) & ((beat_cnt + BW'(1)) == burst_lim);
    assign burst_done = limit_hit | (slot_free & (~g_vld | g_mask | ~cfg_en));

    always_comb begin
        state_nxt = state;
        ch_rd_en  = '0;
        case (state)
            ST_IDLE: begin
                if (cfg_en && (|req)) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                state_nxt = pick_found ? ST_BURST : ST_IDLE;
            end
            ST_BURST: begin
                ch_rd_en[grant] = pop;
                if (burst_done) begin
                    state_nxt = cfg_en ? ST_ARB : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            beat_cnt  <= '0;
            burst_lim <= '0;
        end else begin
            state <= state_nxt;
            if (pick_found) begin
                grant     <= pick_idx;
                beat_cnt  <= '0;
                burst_lim <= cfg_burst;
            end else if (pop) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
            if ((state == ST_BURST) && burst_done) begin
                rr_ptr <= grant_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_id   <= '0;
        end else if (pop) begin
            m_vld  <= 1'b1;
            m_data <= g_data;
            m_id   <= grant;
        end else if (m_rdy) begin
            m_vld <= 1'b0;
        end
    end

    assign busy = (state == ST_ARB) | (state == ST_BURST) | m_vld;

endmodule
